// File: rtl/cr_huf_comp_sa_st_rd.sv
// cr_huf_comp_sa_st_rd
// Symbol-assigner-side reader of the symbol-table code LUT. It waits for a
// ready table (or a pass-through block) and streams every LUT entry
// {symbol, code, length} downstream under valid/ready flow control, then
// pulses sa_st_read_done. A credit-controlled skid FIFO of depth RD_LAT+2
// absorbs the fixed LUT read latency without ever overflowing.
//
// Build option: define CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN to drop returned words
// whose length is zero before they reach the FIFO, so only used symbols are
// emitted. Left undefined, all NUM_SYM entries are emitted.
module cr_huf_comp_sa_st_rd #(
    parameter int NUM_SYM = 286,
    parameter int AW      = 9,
    parameter int CODE_W  = 16,
    parameter int LEN_W   = 5,
    parameter int RD_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sa_blk_start,
    input  logic                    st_rdy_to_sa,
    input  logic                    st_tbl_rdy,
    input  logic                    st_pass_thru,
    output logic                    lut_rd_en,
    output logic [AW-1:0]           lut_rd_addr,
    input  logic [CODE_W+LEN_W-1:0] lut_rd_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [AW-1:0]           out_sym,
    output logic [CODE_W-1:0]       out_code,
    output logic [LEN_W-1:0]        out_len,
    output logic                    sa_busy,
    output logic                    sa_st_read_done
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = AW + CODE_W + LEN_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TBL,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [AW-1:0]     rd_cnt;
    logic [CNT_W-1:0]  outst;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ENT_W-1:0]  fifo_mem [DEPTH];

    logic [RD_LAT-1:0] pipe_vld;
    logic [AW-1:0]     pipe_addr [RD_LAT];

    logic              credit_ok;
    logic              rd_last;
    logic              ret_vld;
    logic [AW-1:0]     ret_sym;
    logic [CODE_W-1:0] ret_code;
    logic [LEN_W-1:0]  ret_len;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A read may issue only while reads in flight plus buffered entries leave room in the FIFO.
    assign credit_used = {1'b0, outst} + {1'b0, fifo_cnt};
    assign credit_ok   = (credit_used < (CNT_W + 1)'(DEPTH));
    assign rd_last     = (rd_cnt == AW'(NUM_SYM - 1));

    assign ret_vld  = pipe_vld[RD_LAT-1];
    assign ret_sym  = pipe_addr[RD_LAT-1];
    assign ret_code = lut_rd_data[CODE_W-1:0];
    assign ret_len  = lut_rd_data[CODE_W+LEN_W-1:CODE_W];

`ifdef CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN
    // Unused symbols never enter the FIFO; their credit returns via outst alone.
    assign push = ret_vld && (ret_len != '0);
`else
    assign push = ret_vld;
`endif

    assign pop     = out_vld && out_rdy;
    assign out_vld = (fifo_cnt != '0);
    assign {out_sym, out_code, out_len} = fifo_mem[rd_ptr];

    assign lut_rd_addr = rd_cnt;
    assign sa_busy     = (state != IDLE);

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and read strobe.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        lut_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (sa_blk_start && st_rdy_to_sa) begin
                    if (st_pass_thru)    state_nxt = DONE;
                    else if (st_tbl_rdy) state_nxt = READ;
                    else                 state_nxt = WAIT_TBL;
                end
            end
            WAIT_TBL: begin
                if (st_tbl_rdy) state_nxt = READ;
            end
            READ: begin
                lut_rd_en = credit_ok;
                if (credit_ok && rd_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (outst == '0 && fifo_cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read address counter: restarts at 0 for every block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 rd_cnt <= '0;
        else if (state == IDLE)     rd_cnt <= '0;
        else if (lut_rd_en)         rd_cnt <= rd_cnt + AW'(1);
    end

    // Address tag pipe aligned with the LUT read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
        end else begin
            pipe_vld[0]  <= lut_rd_en;
            pipe_addr[0] <= lut_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    // Reads in flight: up on issue, down when the word returns (kept or dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst <= '0;
        else        outst <= outst + CNT_W'(lut_rd_en) - CNT_W'(ret_vld);
    end

    // Skid FIFO; push and pop in the same cycle leave the occupancy unchanged.
    // NOTE: the storage is reset as well, so the output fields read 0 out of
    // reset rather than whatever the flops powered up with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {ret_sym, ret_code, ret_len};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    // Done pulse: one cycle, following the single DONE state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sa_st_read_done <= 1'b0;
        else        sa_st_read_done <= (state == DONE);
    end

    // The credit scheme guarantees the FIFO never overflows.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_cnt == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_cr_huf_comp_sa_st_rd.sv
// tb_cr_huf_comp_sa_st_rd
// Self-checking bench: a behavioural LUT with fixed read latency feeds the DUT,
// a negedge monitor logs reads, pops, stalls and done pulses, and each test task
// compares those logs with a symbol-order reference list built from the LUT.
`timescale 1ns/1ps
module tb_cr_huf_comp_sa_st_rd;

    localparam int NUM_SYM = 286;
    localparam int AW      = 9;
    localparam int CODE_W  = 16;
    localparam int LEN_W   = 5;
    localparam int RD_LAT  = 2;
    localparam int DW      = CODE_W + LEN_W;
    localparam int DEPTH   = RD_LAT + 2;

`ifdef CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sa_blk_start = 1'b0;
    logic              st_rdy_to_sa = 1'b0;
    logic              st_tbl_rdy = 1'b0;
    logic              st_pass_thru = 1'b0;
    logic              lut_rd_en;
    logic [AW-1:0]     lut_rd_addr;
    logic [DW-1:0]     lut_rd_data = '0;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [AW-1:0]     out_sym;
    logic [CODE_W-1:0] out_code;
    logic [LEN_W-1:0]  out_len;
    logic              sa_busy;
    logic              sa_st_read_done;

    cr_huf_comp_sa_st_rd dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sa_blk_start    (sa_blk_start),
        .st_rdy_to_sa    (st_rdy_to_sa),
        .st_tbl_rdy      (st_tbl_rdy),
        .st_pass_thru    (st_pass_thru),
        .lut_rd_en       (lut_rd_en),
        .lut_rd_addr     (lut_rd_addr),
        .lut_rd_data     (lut_rd_data),
        .out_vld         (out_vld),
        .out_rdy         (out_rdy),
        .out_sym         (out_sym),
        .out_code        (out_code),
        .out_len         (out_len),
        .sa_busy         (sa_busy),
        .sa_st_read_done (sa_st_read_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                sym;
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
        int                cyc;
    } pop_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [CODE_W-1:0] lut_code [NUM_SYM];
    logic [LEN_W-1:0]  lut_len  [NUM_SYM];
    int                exp_sym [$];

    pop_t pops [$];
    int   rd_addrs [$];
    int   rd_cycs [$];
    int   done_cycs [$];
    int   first_vld = -1;
    int   stall_cnt = 0;
    int   stall_err = 0;
    int   max_inflight = 0;

    int                issued = 0;
    int                popped = 0;
    int                dropped = 0;
    bit                prev_stall = 1'b0;
    logic [AW-1:0]     prev_sym;
    logic [CODE_W-1:0] prev_code;
    logic [LEN_W-1:0]  prev_len;
    bit                line_vld  [RD_LAT];
    int                line_addr [RD_LAT];

    // Cycle index, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor plus behavioural LUT returning data RD_LAT cycles after each read.
    always @(negedge clk) begin
        if (!rst_n) begin
            issued     = 0;
            popped     = 0;
            dropped    = 0;
            prev_stall = 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                line_vld[i]  = 1'b0;
                line_addr[i] = 0;
            end
            lut_rd_data = DW'($urandom);
        end else begin
            if (lut_rd_en) begin
                rd_addrs.push_back(int'(lut_rd_addr));
                rd_cycs.push_back(cyc);
                issued++;
            end
            if (issued - popped - dropped > max_inflight) max_inflight = issued - popped - dropped;
            if (out_vld && first_vld < 0) first_vld = cyc;
            if (prev_stall && (!out_vld || out_sym !== prev_sym ||
                               out_code !== prev_code || out_len !== prev_len))
                stall_err++;
            if (out_vld && !out_rdy) stall_cnt++;
            prev_stall = out_vld && !out_rdy;
            prev_sym   = out_sym;
            prev_code  = out_code;
            prev_len   = out_len;
            if (out_vld && out_rdy) begin
                pops.push_back('{int'(out_sym), out_code, out_len, cyc});
                popped++;
            end
            if (sa_st_read_done) done_cycs.push_back(cyc);

            if (line_vld[RD_LAT-1]) begin
                lut_rd_data = {lut_len[line_addr[RD_LAT-1]], lut_code[line_addr[RD_LAT-1]]};
                if (SKIP_ZERO && lut_len[line_addr[RD_LAT-1]] == '0) dropped++;
            end else begin
                lut_rd_data = DW'($urandom);
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                line_vld[i]  = line_vld[i-1];
                line_addr[i] = line_addr[i-1];
            end
            line_vld[0]  = lut_rd_en;
            line_addr[0] = int'(lut_rd_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        pops.delete();
        rd_addrs.delete();
        rd_cycs.delete();
        done_cycs.delete();
        first_vld    = -1;
        stall_cnt    = 0;
        stall_err    = 0;
        max_inflight = 0;
    endtask

    // mode 0: every length non-zero; 1: random with ~1/4 zeros; 2: only 0, 65, 256 used.
    task automatic fill_lut(input int mode);
        for (int i = 0; i < NUM_SYM; i++) begin
            lut_code[i] = CODE_W'($urandom);
            if (mode == 0)
                lut_len[i] = LEN_W'($urandom_range(16, 1));
            else if (mode == 1)
                lut_len[i] = ($urandom_range(3, 0) == 0) ? '0 : LEN_W'($urandom_range(16, 1));
            else
                lut_len[i] = (i == 0 || i == 65 || i == 256) ? LEN_W'($urandom_range(16, 1)) : '0;
        end
        exp_sym.delete();
        for (int i = 0; i < NUM_SYM; i++)
            if (!(SKIP_ZERO && lut_len[i] == '0)) exp_sym.push_back(i);
    endtask

    function automatic int first_mismatch();
        for (int i = 0; i < pops.size() && i < exp_sym.size(); i++) begin
            if (pops[i].sym != exp_sym[i] || pops[i].code !== lut_code[exp_sym[i]] ||
                pops[i].len !== lut_len[exp_sym[i]])
                return i;
        end
        return -1;
    endfunction

    task automatic start_block(input bit pass, input bit tbl, output int s);
        st_rdy_to_sa = 1'b1;
        st_pass_thru = pass;
        st_tbl_rdy   = tbl;
        sa_blk_start = 1'b1;
        s = cyc;
        tick();
        sa_blk_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (done_cycs.size() == 0) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            tick();
            n++;
        end
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({lut_rd_en, lut_rd_addr, out_vld, out_sym, out_code, out_len, sa_busy, sa_st_read_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b addr=%0d vld=%b sym=%0d code=%h len=%0d busy=%b done=%b want all 0",
                     lut_rd_en, lut_rd_addr, out_vld, out_sym, out_code, out_len, sa_busy, sa_st_read_done);
        end
        rst_n = 1'b1;
        st_rdy_to_sa = 1'b1;
        st_tbl_rdy   = 1'b1;
        clear_logs();
        repeat (4) tick();
        total++;
        if (sa_busy !== 1'b0 || rd_addrs.size() != 0) begin
            bad++;
            $display("FAIL idle_without_start: got busy=%b reads=%0d want busy=0 reads=0", sa_busy, rd_addrs.size());
        end
    endtask

    task automatic test_pass_thru();
        int s;
        bit ok;
        clear_logs();
        out_rdy = 1'b1;
        start_block(1'b1, 1'b0, s);
        wait_done(20, ok);
        st_pass_thru = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL pass_thru_timeout: got no done want done"); end
        total++;
        if (done_cycs.size() != 1 || done_cycs[0] != s + 2) begin
            bad++;
            $display("FAIL pass_thru_done: got count=%0d cyc=%0d want count=1 cyc=%0d",
                     done_cycs.size(), (done_cycs.size() > 0) ? done_cycs[0] - s : -1, 2);
        end
        total++;
        if (rd_addrs.size() != 0 || first_vld != -1) begin
            bad++;
            $display("FAIL pass_thru_no_reads: got reads=%0d first_vld=%0d want 0 and -1", rd_addrs.size(), first_vld);
        end
    endtask

    task automatic test_full_table();
        int s;
        bit ok;
        int bad_rd = -1;
        int bad_cy = -1;
        int mm;
        fill_lut(0);
        clear_logs();
        out_rdy = 1'b1;
        start_block(1'b0, 1'b1, s);
        wait_done(1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout: got no done want done"); end
        for (int i = 0; i < rd_addrs.size(); i++) if (bad_rd < 0 && rd_addrs[i] != i) bad_rd = i;
        total++;
        if (rd_addrs.size() != NUM_SYM || bad_rd != -1) begin
            bad++;
            $display("FAIL full_reads: got count=%0d first_bad=%0d want count=%0d first_bad=-1", rd_addrs.size(), bad_rd, NUM_SYM);
        end
        total++;
        if (rd_cycs.size() == 0 || rd_cycs[0] != s + 1) begin
            bad++;
            $display("FAIL full_first_read: got offset=%0d want 1", (rd_cycs.size() > 0) ? rd_cycs[0] - s : -1);
        end
        total++;
        if (first_vld != s + 1 + RD_LAT + 1) begin
            bad++;
            $display("FAIL full_first_vld: got offset=%0d want %0d", first_vld - s, 1 + RD_LAT + 1);
        end
        mm = first_mismatch();
        total++;
        if (pops.size() != exp_sym.size() || mm != -1) begin
            bad++;
            $display("FAIL full_stream: got count=%0d first_bad=%0d want count=%0d first_bad=-1", pops.size(), mm, exp_sym.size());
        end
        for (int i = 0; i < pops.size(); i++) if (bad_cy < 0 && pops[i].cyc != pops[0].cyc + i) bad_cy = i;
        total++;
        if (bad_cy != -1) begin
            bad++;
            $display("FAIL full_one_per_cycle: got gap at entry %0d want none", bad_cy);
        end
        total++;
        if (done_cycs.size() != 1 || pops.size() == 0 || done_cycs[0] <= pops[pops.size()-1].cyc || sa_busy !== 1'b0) begin
            bad++;
            $display("FAIL full_done: got count=%0d busy=%b want count=1 after last pop busy=0", done_cycs.size(), sa_busy);
        end
    endtask

    task automatic test_backpressure();
        int s;
        int n = 0;
        int mm;
        fill_lut(1);
        clear_logs();
        out_rdy = 1'b0;
        start_block(1'b0, 1'b1, s);
        while (done_cycs.size() == 0 && n < 3000) begin
            out_rdy      = (cyc % 3 == 0);
            sa_blk_start = (n == 50);
            tick();
            n++;
        end
        sa_blk_start = 1'b0;
        out_rdy = 1'b1;
        repeat (10) tick();
        total++;
        if (done_cycs.size() != 1) begin
            bad++;
            $display("FAIL bp_done: got count=%0d want 1", done_cycs.size());
        end
        total++;
        if (max_inflight > DEPTH) begin
            bad++;
            $display("FAIL bp_inflight: got max=%0d want <=%0d", max_inflight, DEPTH);
        end
        total++;
        if (stall_cnt == 0 || stall_err != 0) begin
            bad++;
            $display("FAIL bp_stable: got stalls=%0d unstable=%0d want stalls>0 unstable=0", stall_cnt, stall_err);
        end
        mm = first_mismatch();
        total++;
        if (pops.size() != exp_sym.size() || mm != -1) begin
            bad++;
            $display("FAIL bp_stream: got count=%0d first_bad=%0d want count=%0d first_bad=-1", pops.size(), mm, exp_sym.size());
        end
        total++;
        if (rd_addrs.size() != NUM_SYM) begin
            bad++;
            $display("FAIL bp_ignored_start: got reads=%0d want %0d", rd_addrs.size(), NUM_SYM);
        end
    endtask

    task automatic test_late_table();
        int s;
        int t;
        bit ok;
        fill_lut(0);
        clear_logs();
        out_rdy = 1'b1;
        start_block(1'b0, 1'b0, s);
        for (int i = 0; i < 10; i++) begin
            st_rdy_to_sa = (i < 4);
            tick();
        end
        total++;
        if (rd_addrs.size() != 0 || sa_busy !== 1'b1) begin
            bad++;
            $display("FAIL late_hold: got reads=%0d busy=%b want reads=0 busy=1", rd_addrs.size(), sa_busy);
        end
        st_tbl_rdy = 1'b1;
        t = cyc;
        tick();
        wait_done(1000, ok);
        st_rdy_to_sa = 1'b1;
        total++;
        if (rd_cycs.size() == 0 || rd_cycs[0] != t + 1) begin
            bad++;
            $display("FAIL late_read_entry: got offset=%0d want 1", (rd_cycs.size() > 0) ? rd_cycs[0] - t : -1);
        end
        total++;
        if (!ok || pops.size() != NUM_SYM || done_cycs.size() != 1) begin
            bad++;
            $display("FAIL late_complete: got pops=%0d done=%0d want pops=%0d done=1", pops.size(), done_cycs.size(), NUM_SYM);
        end
    endtask

    task automatic test_zero_len();
        int s;
        int n = 0;
        int mm;
        fill_lut(2);
        clear_logs();
        start_block(1'b0, 1'b1, s);
        while (done_cycs.size() == 0 && n < 2000) begin
            out_rdy = 1'($urandom_range(1, 0));
            tick();
            n++;
        end
        out_rdy = 1'b1;
        repeat (5) tick();
        mm = first_mismatch();
        total++;
        if (pops.size() != exp_sym.size() || mm != -1) begin
            bad++;
            $display("FAIL zero_len_stream: got count=%0d first_bad=%0d want count=%0d first_bad=-1", pops.size(), mm, exp_sym.size());
        end
        total++;
        if (done_cycs.size() != 1 || pops.size() == 0 || done_cycs[0] <= pops[pops.size()-1].cyc) begin
            bad++;
            $display("FAIL zero_len_done: got count=%0d want 1 after last pop", done_cycs.size());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        int n = 0;
        bit ok;
        int mm;
        fill_lut(0);
        clear_logs();
        out_rdy = 1'b1;
        start_block(1'b0, 1'b1, s);
        while (rd_addrs.size() <= 100 && n < 500) begin
            tick();
            n++;
        end
        total++;
        if (rd_addrs.size() <= 100) begin
            bad++;
            $display("FAIL rst_mid_reach: got reads=%0d want >100", rd_addrs.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({lut_rd_en, lut_rd_addr, out_vld, out_sym, out_code, out_len, sa_busy, sa_st_read_done} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got en=%b addr=%0d vld=%b sym=%0d busy=%b done=%b want all 0",
                     lut_rd_en, lut_rd_addr, out_vld, out_sym, sa_busy, sa_st_read_done);
        end
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        total++;
        if (done_cycs.size() != 0 || sa_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_done: got done=%0d busy=%b want done=0 busy=0", done_cycs.size(), sa_busy);
        end
        clear_logs();
        start_block(1'b0, 1'b1, s);
        wait_done(1000, ok);
        mm = first_mismatch();
        total++;
        if (!ok || rd_addrs.size() == 0 || rd_addrs[0] != 0 || pops.size() != exp_sym.size() || mm != -1) begin
            bad++;
            $display("FAIL rst_mid_next_block: got first_addr=%0d pops=%0d first_bad=%0d want 0 %0d -1",
                     (rd_addrs.size() > 0) ? rd_addrs[0] : -1, pops.size(), mm, exp_sym.size());
        end
    endtask

    initial begin
        test_reset();
        test_pass_thru();
        test_full_table();
        test_backpressure();
        test_late_table();
        test_zero_len();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cr_huf_comp_sa_st_rd.md
Name: cr_huf_comp_sa_st_rd

Overview:
- Symbol-assigner-side reader of the symbol-table (ST) code LUT in the Huffman compressor.
- Waits until the ST side reports a table, or a pass-through block, as ready to SA.
- Streams every LUT entry (symbol, code, length) to the SA datapath under valid/ready backpressure, then pulses sa_st_read_done so the ST FSM can return to idle.
- Absorbs fixed LUT read latency with a credit-controlled skid FIFO.

Parameters:
NUM_SYM, 286, number of LUT entries read per table (addresses 0..NUM_SYM-1)
AW, 9, LUT address / symbol width; 2^AW >= NUM_SYM
CODE_W, 16, Huffman code width
LEN_W, 5, code length width
RD_LAT, 2, cycles from lut_rd_en to lut_rd_data valid (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sa_blk_start  in  1  SA requests the table for the next block; level, sampled in IDLE
st_rdy_to_sa  in  1  ST side holds a block ready for SA (pass-through or table pending)
st_tbl_rdy  in  1  ST LUT fully written and readable
st_pass_thru  in  1  current block is pass-through (no table); valid while st_rdy_to_sa=1
lut_rd_en  out  1  LUT read strobe
lut_rd_addr  out  AW  LUT read address
lut_rd_data  in  CODE_W+LEN_W  {len, code}; valid exactly RD_LAT cycles after lut_rd_en
out_vld  out  1  output entry valid
out_rdy  in  1  downstream accept
out_sym  out  AW  symbol index (LUT address of the entry)
out_code  out  CODE_W  code bits
out_len  out  LEN_W  code length
sa_busy  out  1  high in every state except IDLE
sa_st_read_done  out  1  single-cycle done pulse to the ST FSM

Behaviour:
- Reset: FSM=IDLE; address counter, outstanding count and FIFO cleared; all outputs 0. Reset mid-read aborts the read. In-flight LUT data is discarded. No done pulse is issued.
- States: IDLE, WAIT_TBL, READ, DRAIN, DONE.
- IDLE, when sa_blk_start & st_rdy_to_sa:
  - st_pass_thru=1 -> DONE (no LUT reads).
  - else st_tbl_rdy=1 -> READ.
  - else -> WAIT_TBL.
- WAIT_TBL: st_tbl_rdy=1 -> READ. Stays otherwise; st_rdy_to_sa dropping has no effect.
- READ:
  - Issue lut_rd_en with lut_rd_addr=counter whenever outstanding + FIFO occupancy < FIFO depth. FIFO depth = RD_LAT+2.
  - First read is issued in the first READ cycle. Counter increments per issued read.
  - Issuing address NUM_SYM-1 moves to DRAIN; no wrap.
- Return path: each returning word is tagged with its address through an RD_LAT-deep shift pipe and pushed into the FIFO. The credit scheme makes overflow impossible; an overflow is an assertion failure.
- Output: out_vld = FIFO non-empty; fields come from the FIFO head.
  - Pop on out_vld & out_rdy.
  - Fields are stable while out_vld=1 and out_rdy=0.
  - Entries leave in ascending symbol order.
- Push and pop may occur in the same cycle. Occupancy is unchanged, and the credit is freed for the next cycle.
- Full-throughput: with out_rdy held 1, one entry per cycle. First out_vld appears RD_LAT+1 cycles after READ entry.
- DRAIN: outstanding=0 and FIFO empty -> DONE.
- DONE: sa_st_read_done=1 for exactly one cycle, then -> IDLE. The pulse is never repeated until a new block starts.
- A new sa_blk_start is ignored outside IDLE.
- out_len=0 entries (unused symbols) are handled by the optional feature below.

Optional Feature:
- CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN
- Defined: returning words with len==0 are dropped before the FIFO push. Their credit frees immediately. The output stream carries only used symbols, still in ascending order. Done timing follows the last returned word.
- Undefined: all NUM_SYM entries are emitted, including len==0.

Test Plan:
- Pass-through: st_rdy_to_sa=1, st_pass_thru=1, sa_blk_start=1 -> no lut_rd_en; sa_st_read_done pulses 2 cycles after start; out_vld stays 0.
- Full table, out_rdy=1, RD_LAT=2, NUM_SYM=286 -> 286 entries, out_sym 0..285 contiguous, one per cycle. First out_vld 3 cycles after READ entry. Single done pulse after last pop.
- Backpressure: out_rdy toggled 1-of-3 cycles -> at most RD_LAT+2 reads outstanding plus buffered; no entry lost or duplicated; fields stable while stalled.
- Late table: start with st_tbl_rdy=0 for 10 cycles -> FSM holds in WAIT_TBL with no reads; READ entered on the cycle after st_tbl_rdy=1.
- Zero-length (macro defined): LUT with only symbols 0, 65, 256 non-zero -> exactly 3 outputs, in that order, then done. Macro undefined -> 286 outputs.
- Reset at entry 100 of READ -> all outputs 0 next cycle, no done pulse; a following block reads from address 0.
